mmu_out_deskew: RTL

MMU_OUT_DESKEW -- requirements
Module: mmu_out_deskew

---
 rtl/mmu_out_deskew.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mmu_out_deskew.sv
// Realigns skewed systolic-array column sums into whole rows and queues them in a small output FIFO.
// Optional row counter / out_last generation is enabled by defining MMU_DESKEW_ROWCNT_EN.
module mmu_out_deskew #(
   parameter int N      = 4,
   parameter int LANE_W = 32,
   parameter int ROWS   = 4,
   parameter int DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N*LANE_W-1:0]   acc_out,
   input  logic                  in_valid,
   input  logic                  flush,
   output logic [N*LANE_W-1:0]   out_row,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  ovf
);

   localparam int AW = $clog2(DEPTH);

   if (N < 1 || ROWS < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
      $error("mmu_out_deskew: N, ROWS >= 1 and DEPTH a power of two >= 2 required");
   end

   logic [N*LANE_W-1:0] w_aligned;
   logic                w_vld_d;

   // Lane k lags lane 0 by k cycles, so it needs N-1-k stages to line up with lane N-1.
   for (genvar k = 0; k < N; k++) begin : g_lane
      localparam int D = N - 1 - k;
      if (D == 0) begin : g_direct
         assign w_aligned[k*LANE_W +: LANE_W] = acc_out[k*LANE_W +: LANE_W];
      end else begin : g_dly
         logic [LANE_W-1:0] r_sr [D];
         always_ff @(posedge clk) begin
            r_sr[0] <= acc_out[k*LANE_W +: LANE_W];
            for (int i = 1; i < D; i++) begin
               r_sr[i] <= r_sr[i-1];
            end
         end
         assign w_aligned[k*LANE_W +: LANE_W] = r_sr[D-1];
      end
   end

   if (N == 1) begin : g_vld_direct
      assign w_vld_d = in_valid;
   end else begin : g_vld_dly
      logic [N-2:0] r_vld;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_vld <= '0;
         end else if (flush) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < N - 1; i++) begin
               r_vld[i] <= r_vld[i-1];
            end
         end
      end
      assign w_vld_d = r_vld[N-2];
   end

   logic [N*LANE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic                r_ovf;
   logic                w_full;
   logic                w_pop;
   logic                w_wr;
   logic                w_drop;

   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still take the row.
   assign w_wr      = w_vld_d && (!w_full || w_pop);
   assign w_drop    = w_vld_d && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr && !flush) begin
         r_mem[r_wr_ptr] <= w_aligned;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_wr) begin
            r_count <= r_count - (AW+1)'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Gated so stale or uninitialised storage never shows while empty or in reset.
   assign out_row = out_valid ? r_mem[r_rd_ptr] : '0;
   assign ovf     = r_ovf;

`ifdef MMU_DESKEW_ROWCNT_EN
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [RW-1:0] r_row_cnt;
   logic          w_row_last;

   assign w_row_last = (r_row_cnt == RW'(ROWS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row_cnt <= '0;
      end else if (flush) begin
         r_row_cnt <= '0;
      end else if (w_pop) begin
         r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
      end
   end

   assign out_last = out_valid && w_row_last;
`else
   assign out_last = 1'b0;
`endif

endmodule
